// File: rtl/alu_shift_pkg.sv
// Shared types for the multi-cycle shift/rotate ALU block.
// Operation codes, FSM states and effective-count helper.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL = 3'b000,
    OP_SHR = 3'b001,
    OP_SAR = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100,
    OP_RCL = 3'b101,
    OP_RCR = 3'b110,
    OP_FSL = 3'b111
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // Rotates wrap at the word size, carry rotates use the raw
  // count, everything else saturates once the word is all fill.
  function automatic int unsigned eff_count(
    shift_op_e   op,
    int unsigned n,
    int unsigned w
  );
    int unsigned e;
    case (op)
      OP_ROL, OP_ROR: e = n & (w - 1);
      OP_RCL, OP_RCR: e = n;
      default:        e = (n > w) ? w : n;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational shifter for one FSM step of up to STEP_WIDTH bits.
// Moves {carry, word, fill} by k single-bit positions.
module shift_step_unit
  import alu_shift_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int STEP_WIDTH = 4,
  parameter int CW         = $clog2(WORD_WIDTH) + 1
) (
  input  shift_op_e             op,
  input  logic [CW-1:0]         k,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [WORD_WIDTH-2:0] fill,
  input  logic                  carry,
  output logic [WORD_WIDTH-1:0] word_nxt,
  output logic [WORD_WIDTH-2:0] fill_nxt,
  output logic                  carry_nxt
);

  localparam int W = WORD_WIDTH;

  // Chain of single-position steps, each enabled while i < k.
  always_comb begin
    logic [W-1:0] w;
    logic [W-2:0] f;
    logic         c;
    logic         t;
    w = word;
    f = fill;
    c = carry;
    t = 1'b0;
    for (int i = 0; i < STEP_WIDTH; i++) begin
      if (i < int'(k)) begin
        unique case (op)
          OP_SHL: begin
            c = w[W-1];
            w = {w[W-2:0], 1'b0};
          end
          OP_SHR: begin
            c = w[0];
            w = {1'b0, w[W-1:1]};
          end
          OP_SAR: begin
            c = w[0];
            w = {w[W-1], w[W-1:1]};
          end
          OP_ROL: begin
            c = w[W-1];
            w = {w[W-2:0], w[W-1]};
          end
          OP_ROR: begin
            c = w[0];
            w = {w[0], w[W-1:1]};
          end
          OP_RCL: begin
            t = w[W-1];
            w = {w[W-2:0], c};
            c = t;
          end
          OP_RCR: begin
            t = w[0];
            w = {c, w[W-1:1]};
            c = t;
          end
          OP_FSL: begin
            c = w[W-1];
            w = {w[W-2:0], f[W-2]};
            f = {f[W-3:0], 1'b0};
          end
        endcase
      end
    end
    word_nxt  = w;
    fill_nxt  = f;
    carry_nxt = c;
  end

endmodule

// File: rtl/shift_seq_block.sv
// Multi-cycle shift/rotate block behind valid/ready handshakes.
// Shifts at most STEP_WIDTH positions per clock.
module shift_seq_block
  import alu_shift_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic [WORD_WIDTH-2:0] c_i,
  input  logic                  cf_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  cf_o,
  output logic                  zf_o,
  output logic                  of_o,
  output logic                  pf_o,
  output logic                  sf_o
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W) + 1;

  state_e          state, state_nxt;
  shift_op_e       op_q;
  logic [W-1:0]    word_q, word_nxt;
  logic [W-2:0]    fill_q, fill_nxt;
  logic            carry_q, carry_nxt;
  logic            amsb_q;
  logic [CW-1:0]   rem_q, rem_nxt, k;
  logic [CW-1:0]   cnt, e_in;
  logic            accept;
  logic            run_last;
  logic            load_res;
  logic [W-1:0]    res_d;
  logic            cf_d, msb_d;
  logic [W-1:0]    r_q;
  logic            cf_q, zf_q, of_q, pf_q, sf_q;
  logic            unused_b;

  assign cnt      = b_i[CW-1:0];
  assign unused_b = ^b_i[W-1:CW];
  assign e_in     = CW'(eff_count(shift_op_e'(op_i), 32'(cnt), W));

  assign ready_o  = (state == S_IDLE) | ((state == S_DONE) & ready_i);
  assign valid_o  = (state == S_DONE);
  assign accept   = valid_i & ready_o;

  assign k        = (rem_q > CW'(STEP_WIDTH)) ? CW'(STEP_WIDTH) : rem_q;
  assign rem_nxt  = rem_q - k;
  assign run_last = (state == S_RUN) & (rem_nxt == '0);

  shift_step_unit #(
    .WORD_WIDTH (W),
    .STEP_WIDTH (STEP_WIDTH),
    .CW         (CW)
  ) u_step (
    .op        (op_q),
    .k         (k),
    .word      (word_q),
    .fill      (fill_q),
    .carry     (carry_q),
    .word_nxt  (word_nxt),
    .fill_nxt  (fill_nxt),
    .carry_nxt (carry_nxt)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state; a zero count skips RUN entirely.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nxt = (e_in == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (rem_nxt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (accept)
          state_nxt = (e_in == '0) ? S_DONE : S_RUN;
        else if (ready_i)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result source: pass-through on zero count, else final step.
  always_comb begin
    load_res = (accept & (e_in == '0)) | run_last;
    res_d    = accept ? a_i : word_nxt;
    cf_d     = accept ? cf_i : carry_nxt;
    msb_d    = accept ? a_i[W-1] : amsb_q;
  end

  // Working registers and registered result/flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= OP_SHL;
      word_q  <= '0;
      fill_q  <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      rem_q   <= '0;
      r_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      pf_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= shift_op_e'(op_i);
        word_q  <= a_i;
        fill_q  <= c_i;
        carry_q <= cf_i;
        amsb_q  <= a_i[W-1];
        rem_q   <= e_in;
      end else if (state == S_RUN) begin
        word_q  <= word_nxt;
        fill_q  <= fill_nxt;
        carry_q <= carry_nxt;
        rem_q   <= rem_nxt;
      end
      if (load_res) begin
        r_q  <= res_d;
        cf_q <= cf_d;
        zf_q <= ~|res_d;
        of_q <= res_d[W-1] ^ msb_d;
        pf_q <= res_d[0];
        sf_q <= res_d[W-1];
      end
    end
  end

  assign r_o  = r_q;
  assign cf_o = cf_q;
  assign zf_o = zf_q;
  assign of_o = of_q;
  assign pf_o = pf_q;
  assign sf_o = sf_q;

endmodule

// File: tb/tb_shift_seq_block.sv
// Directed bench for shift_seq_block (32-bit word, 4-bit step).
// Hand-computed results, flags and latencies.
module tb_shift_seq_block;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [30:0] c_i;
  logic        cf_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] r_o;
  logic        cf_o, zf_o, of_o, pf_o, sf_o;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic [31:0] r_hold;
  logic [4:0]  f_hold;

  always #5 clk = ~clk;

  shift_seq_block #(
    .WORD_WIDTH (32),
    .STEP_WIDTH (4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .cf_i    (cf_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .r_o     (r_o),
    .cf_o    (cf_o),
    .zf_o    (zf_o),
    .of_o    (of_o),
    .pf_o    (pf_o),
    .sf_o    (sf_o)
  );

  function automatic logic [4:0] flags();
    return {cf_o, zf_o, of_o, pf_o, sf_o};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                       logic [30:0] c, logic cf);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; c_i = c; cf_i = cf;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    a_i = '1; b_i = '0; c_i = '0; cf_i = ~cf; op_i = 3'b000;
  endtask

  task automatic wait_valid(output int l);
    l = 1;
    while (!valid_o && l < 200) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic run(string tag, logic [2:0] op, logic [31:0] a,
                     logic [31:0] b, logic [30:0] c, logic cf,
                     logic [31:0] er, logic [4:0] ef, int el);
    int l;
    start(op, a, b, c, cf);
    wait_valid(l);
    check({tag, "_lat"}, 32'(l), 32'(el));
    check({tag, "_r"}, r_o, er);
    check({tag, "_flags"}, {27'd0, flags()}, {27'd0, ef});
    consume();
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    op_i    = 3'b000;
    a_i     = '0;
    b_i     = '0;
    c_i     = '0;
    cf_i    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_r", r_o, 32'd0);
    check("rst_flags", {27'd0, flags()}, 32'd0);
    rst_ni = 1'b1;

    // flags order: cf zf of pf sf
    run("shl1", 3'b000, 32'h8000_0001, 32'd1, '0, 1'b0,
        32'h0000_0002, 5'b10100, 2);
    run("sar40", 3'b010, 32'h8000_0000, 32'hFFFF_FFE8, '0, 1'b0,
        32'hFFFF_FFFF, 5'b10011, 9);
    run("rcl33", 3'b101, 32'h0000_0001, 32'd33, '0, 1'b0,
        32'h0000_0001, 5'b00010, 10);
    run("ror32", 3'b100, 32'h0000_0001, 32'd32, '0, 1'b1,
        32'h0000_0001, 5'b10010, 1);
    run("fsl8", 3'b111, 32'h1234_5678, 32'd8, 31'h7FFF_FFFF, 1'b1,
        32'h3456_78FF, 5'b00010, 3);
    run("shl32", 3'b000, 32'h0000_0001, 32'd32, '0, 1'b0,
        32'h0000_0000, 5'b11000, 9);
    run("rcr1", 3'b110, 32'h0000_0000, 32'd1, '0, 1'b1,
        32'h8000_0000, 5'b00101, 2);
    run("rol1", 3'b011, 32'h8000_0000, 32'd1, '0, 1'b0,
        32'h0000_0001, 5'b10110, 2);
    run("rol35", 3'b011, 32'h0000_000F, 32'd35, '0, 1'b0,
        32'h0000_0078, 5'b00000, 2);

    // Consumer stalls five cycles with the result pending.
    start(3'b001, 32'h0000_00F0, 32'd4, '0, 1'b1);
    wait_valid(lat);
    check("hold_lat", 32'(lat), 32'd2);
    check("hold_r", r_o, 32'h0000_000F);
    check("hold_flags", {27'd0, flags()}, 32'b00010);
    r_hold = r_o;
    f_hold = flags();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable_r", r_o, r_hold);
      check("hold_stable_f", {27'd0, flags()}, {27'd0, f_hold});
      check("hold_valid", {31'd0, valid_o}, 32'd1);
      check("hold_ready", {31'd0, ready_o}, 32'd0);
    end

    // Release and issue a new request in the same cycle.
    op_i = 3'b000; a_i = 32'h0000_0005; b_i = 32'd0; cf_i = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    check("b2b_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    check("b2b_valid", {31'd0, valid_o}, 32'd1);
    check("b2b_r", r_o, 32'h0000_0005);
    check("b2b_flags", {27'd0, flags()}, 32'b00010);
    consume();

    // Reset in the middle of a long shift.
    start(3'b000, 32'hDEAD_BEEF, 32'd31, '0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("abort_valid", {31'd0, valid_o}, 32'd0);
    check("abort_ready", {31'd0, ready_o}, 32'd1);
    check("abort_r", r_o, 32'd0);
    check("abort_flags", {27'd0, flags()}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    run("shr0", 3'b001, 32'h0000_ABCD, 32'd0, '0, 1'b1,
        32'h0000_ABCD, 5'b10010, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_block.md
# shift_seq_block

Multi-cycle, parametrised shift/rotate execution block for the ALU. Generalises the single-cycle left-shift block to eight operations (logical/arithmetic shifts, rotates, rotate-through-carry, funnel shift) with arbitrary shift counts. It processes at most STEP_WIDTH bit positions per clock and sits behind a valid/ready handshake, so the ALU issue stage can stall on it.

## Interface
- WORD_WIDTH, 32: operand/result width; power of two, ≥ 8.
- STEP_WIDTH, 4: maximum positions shifted per cycle; power of two, 1..WORD_WIDTH.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  block accepts a request this cycle.
- op_i  in  3  operation (shift_op_e).
- a_i  in  WORD_WIDTH  operand to shift.
- b_i  in  WORD_WIDTH  count source; only b_i[CW-1:0] is used, CW = $clog2(WORD_WIDTH)+1.
- c_i  in  WORD_WIDTH-1  funnel fill bits (FSL only).
- cf_i  in  1  carry in.
- valid_o  out  1  result/flags valid.
- ready_i  in  1  consumer accepts result.
- r_o  out  WORD_WIDTH  result.
- cf_o, zf_o, of_o, pf_o, sf_o  out  1 each  carry, zero, overflow, parity, sign.

## Operation
- Ops: 000 SHL (zero fill), 001 SHR (zero fill), 010 SAR (sign fill), 011 ROL, 100 ROR, 101 RCL (WORD_WIDTH+1-bit rotate through carry), 110 RCR, 111 FSL (shift left, fill from c_i MSB first; equivalent to upper WORD_WIDTH bits of {a_i, c_i} << n).
- Raw count n = b_i[CW-1:0], range 0..2·WORD_WIDTH-1. Effective count e: SHL/SHR/SAR/FSL e = min(n, WORD_WIDTH); ROL/ROR e = n mod WORD_WIDTH; RCL/RCR e = n (no reduction).
- Operands, op, e, cf_i and a_i MSB latched on accept; later input changes are ignored.
- FSM: IDLE → (valid_i) → RUN → (remaining = 0) → DONE → (ready_i) → IDLE, or directly to RUN/DONE if a new request is accepted in the same cycle.
- RUN: each cycle shifts k = min(remaining, STEP_WIDTH) positions; remaining −= k. Carry register holds the last bit moved out (for RCL/RCR it is the rotating carry bit).
- e = 0: goes IDLE → DONE, r_o = a_i, cf_o = cf_i.
- Flags registered with the result: cf_o = last bit shifted/rotated out (cf_i if e = 0); zf_o = ~|r_o; pf_o = r_o[0]; sf_o = r_o[WORD_WIDTH-1]; of_o = sf_o ^ latched a_i MSB.
- SHL/SHR/FSL with n ≥ WORD_WIDTH: r_o all fill; cf_o = bit at position WORD_WIDTH-1 / 0 / c_i fill boundary as produced by the step iteration (last bit moved out).

## Timing
- Reset: state IDLE, ready_o = 1, valid_o = 0, r_o = 0, all flags 0. Reset asserted mid-RUN or mid-DONE aborts the operation; no result is produced.
- ready_o = (state == IDLE) | (state == DONE & ready_i). Combinational from ready_i only.
- Latency from accept edge to valid_o: 1 + ceil(e/STEP_WIDTH) cycles (1 cycle for e = 0).
- valid_o stays high and r_o/flags stable until the ready_i handshake; no output changes while valid_o & ~ready_i.
- Back-to-back: accept in DONE with ready_i high loses no cycle.

## Structure
- Package alu_shift_pkg: shift_op_e enum (8 ops), state enum (IDLE/RUN/DONE), function for effective count.
- Sub-module shift_step_unit: combinational, shifts a {carry, word, fill} state by k ∈ 0..STEP_WIDTH for a given op; instantiated once, driven by the FSM registers.

## Test plan
- WORD_WIDTH=32, STEP_WIDTH=4, SHL a=0x8000_0001, n=1 → r=0x0000_0002, cf=1, of=1, sf=0, valid_o 2 cycles after accept.
- SAR a=0x8000_0000, n=40 → r=0xFFFF_FFFF, cf=1, sf=1, zf=0, latency 1+8 cycles.
- RCL a=0x0000_0001, cf_i=0, n=33 → r=0x0000_0001, cf=0 (full 33-bit cycle); ROR a=0x1, n=32 → r=0x1, cf=cf_i, latency 1.
- FSL a=0x1234_5678, c_i=0x7FFF_FFFF(31 bits all ones), n=8 → r=0x3456_78FF, cf=0 (bit 24 of a).
- Hold ready_i=0 for 5 cycles after valid_o: r_o/flags stable, ready_o=0; then ready_i=1 with valid_i=1 → new request accepted same cycle.
- Assert rst_ni low during RUN of n=31 → all outputs reset values immediately; after release, a fresh SHR n=0 completes in 1 cycle with r=a, cf=cf_i.
